// File: rtl/seq_mul_unit.sv
// seq_mul_unit -- sequential signed shift-add multiplier.
//
// Accepts a START strobe while idle, latches A and B, multiplies their
// unsigned magnitudes one bit of |B| per cycle (LSB first), then applies
// the sign in a final FIX cycle and registers the product.
//
// Optional feature macro: SEQ_MUL_EARLY_EXIT_EN
//   defined   : iteration count K = bit-length of |B| (0..N), latency K+1
//   undefined : K = N for every operand, fixed latency N+1
//   S and Carry_out are identical in both builds.
//
// Ports:
//   CLOCK      in   1    sole clock, rising edge
//   RESET      in   1    synchronous active-high reset (priority over START)
//   START      in   1    request strobe, sampled only while idle
//   A          in   N    signed multiplicand (two's complement)
//   B          in   N    signed multiplier (two's complement)
//   S          out  2N   signed product, held until next result or RESET
//   Carry_out  out  1    product does not fit in an N-bit signed value
//   BUSY       out  1    operation in flight (RUN or FIX)
//   DONE       out  1    one-cycle pulse marking a new S / Carry_out
module seq_mul_unit #(
  parameter int N = 8
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           START,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] S,
  output logic           Carry_out,
  output logic           BUSY,
  output logic           DONE
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t         state, state_nx;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic           neg;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  k_start;
  logic [2*N-1:0] s_fix;
  logic           fits;

  // -2^(N-1) maps to 2^(N-1), which is still representable unsigned.
  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? (~x + N'(1)) : x;
  endfunction

`ifdef SEQ_MUL_EARLY_EXIT_EN
  function automatic logic [CW-1:0] bit_len(input logic [N-1:0] x);
    logic [CW-1:0] len;
    len = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (x[i]) len = CW'(i + 1);
    end
    return len;
  endfunction
`endif

  always_comb begin
`ifdef SEQ_MUL_EARLY_EXIT_EN
    k_start = bit_len(mag(B));
`else
    k_start = CW'(N);
`endif
  end

  // Negating a zero magnitude wraps back to zero, so no special case needed.
  always_comb begin
    s_fix = neg ? (~acc + (2*N)'(1)) : acc;
    fits  = (&s_fix[2*N-1:N-1]) | ~(|s_fix[2*N-1:N-1]);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    BUSY     = (state != IDLE);
    case (state)
      IDLE: if (START) state_nx = (k_start == '0) ? FIX : RUN;
      RUN:  if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      S         <= '0;
      Carry_out <= 1'b0;
      DONE      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, mag(A)};
            mplier <= mag(B);
            neg    <= A[N-1] ^ B[N-1];
            cnt    <= k_start;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        FIX: begin
          S         <= s_fix;
          Carry_out <= ~fits;
          DONE      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit -- self-checking bench for seq_mul_unit (N=8).
// A cycle-level behavioural model (plain integer multiply, latency from the
// iteration-count rule) is compared against the DUT every cycle; directed
// cases also check hand-computed literal products and latencies.
// Works with or without SEQ_MUL_EARLY_EXIT_EN defined.
module tb_seq_mul_unit;
  localparam int N = 8;
`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           CLOCK = 1'b0;
  logic           RESET = 1'b1;
  logic           START = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] S;
  logic           Carry_out;
  logic           BUSY;
  logic           DONE;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK = ~CLOCK;

  seq_mul_unit #(.N(N)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .A(A), .B(B),
    .S(S), .Carry_out(Carry_out), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          busy_m = 1'b0;
  bit          done_m = 1'b0;
  logic [15:0] s_m = '0;
  bit          c_m = 1'b0;
  int          fin_cyc = 0;
  logic [15:0] res_q = '0;
  bit          cres_q = 1'b0;

  function automatic int k_of(input int b);
    int m, k;
    if (!EE) return N;
    m = (b < 0) ? -b : b;
    k = 0;
    while (m > 0) begin
      k++;
      m = m >> 1;
    end
    return k;
  endfunction

  always @(posedge CLOCK) begin
    int pa, pb, prod;
    cyc++;
    if (RESET) begin
      busy_m = 1'b0;
      done_m = 1'b0;
      s_m    = '0;
      c_m    = 1'b0;
    end else begin
      done_m = 1'b0;
      if (busy_m) begin
        if (cyc == fin_cyc) begin
          busy_m = 1'b0;
          done_m = 1'b1;
          s_m    = res_q;
          c_m    = cres_q;
        end
      end else if (START) begin
        pa      = $signed(A);
        pb      = $signed(B);
        prod    = pa * pb;
        res_q   = prod[15:0];
        cres_q  = (prod < -128) || (prod > 127);
        busy_m  = 1'b1;
        fin_cyc = cyc + k_of(pb) + 1;
      end
    end
  end

  always @(negedge CLOCK) begin
    check("busy", {31'b0, BUSY}, {31'b0, busy_m});
    check("done", {31'b0, DONE}, {31'b0, done_m});
    check("s", {16'b0, S}, {16'b0, s_m});
    check("carry", {31'b0, Carry_out}, {31'b0, c_m});
  end

  // ---------------- directed stimulus ----------------
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, output int t);
    A = a;
    B = b;
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    t = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat, output int bcnt);
    int n;
    n = 0;
    bcnt = 0;
    while (DONE !== 1'b1 && n < 40) begin
      if (BUSY === 1'b1) bcnt++;
      @(negedge CLOCK);
      n++;
    end
    if (DONE !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    lat = cyc - t0;
  endtask

  initial begin
    int t, t2, lat, bc, d1, dcnt;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, lat, bc, d1, dcnt;
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("rst_s", {16'b0, S}, 32'd0);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    check("rst_carry", {31'b0, Carry_out}, 32'd0);

    // START in the first cycle after RESET deasserts
    RESET = 1'b0;
    start_op(8'd5, 8'd3, t);
    wait_done(t, lat, bc);
    check("p5x3_s", {16'b0, S}, 32'h000F);
    check("p5x3_c", {31'b0, Carry_out}, 32'd0);
    check("p5x3_lat", lat, EE ? 32'd3 : 32'd9);

    repeat (2) @(negedge CLOCK);
    start_op(8'hF9, 8'd6, t);
    wait_done(t, lat, bc);
    check("m7x6_s", {16'b0, S}, 32'hFFD6);
    check("m7x6_c", {31'b0, Carry_out}, 32'd0);
    check("m7x6_lat", lat, EE ? 32'd4 : 32'd9);

    repeat (2) @(negedge CLOCK);
    start_op(8'd100, 8'h80, t);
    wait_done(t, lat, bc);
    check("p100xm128_s", {16'b0, S}, 32'hCE00);
    check("p100xm128_c", {31'b0, Carry_out}, 32'd1);
    check("p100xm128_lat", lat, 32'd9);

    repeat (2) @(negedge CLOCK);
    start_op(8'h80, 8'd0, t);
    wait_done(t, lat, bc);
    check("m128x0_s", {16'b0, S}, 32'd0);
    check("m128x0_c", {31'b0, Carry_out}, 32'd0);
    check("m128x0_lat", lat, EE ? 32'd1 : 32'd9);
    check("m128x0_busy", bc, EE ? 32'd1 : 32'd9);

    // abort on the second RUN cycle
    repeat (2) @(negedge CLOCK);
    start_op(8'd3, 8'd127, t);
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("abort_s", {16'b0, S}, 32'd0);
    check("abort_busy", {31'b0, BUSY}, 32'd0);
    check("abort_done", {31'b0, DONE}, 32'd0);
    RESET = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(negedge CLOCK);
      if (DONE === 1'b1) dcnt++;
    end
    check("abort_nodone", dcnt, 32'd0);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    start_op(8'd2, 8'd2, t);
    wait_done(t, lat, bc);
    check("p2x2_s", {16'b0, S}, 32'd4);
    check("p2x2_lat", lat, EE ? 32'd3 : 32'd9);

    // START while busy is ignored; START in the DONE cycle is accepted
    repeat (2) @(negedge CLOCK);
    start_op(8'd11, 8'hFB, t);
    @(negedge CLOCK);
    A = 8'd9;
    B = 8'd9;
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    wait_done(t, lat, bc);
    d1 = cyc;
    check("p11xm5_s", {16'b0, S}, 32'hFFC9);
    check("p11xm5_lat", lat, EE ? 32'd4 : 32'd9);
    start_op(8'hFE, 8'd4, t2);
    wait_done(t2, lat, bc);
    check("m2x4_s", {16'b0, S}, 32'hFFF8);
    check("m2x4_c", {31'b0, Carry_out}, 32'd0);
    check("m2x4_lat", lat, EE ? 32'd4 : 32'd9);
    // 4 non-DONE cycles between the two pulses when early exit is on
    check("b2b_gap", cyc - d1, EE ? 32'd5 : 32'd10);

    repeat (3) @(negedge CLOCK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mul_unit.md
SEQ_MUL_UNIT -- requirements
Module: seq_mul_unit

Interface
REQ-001 Parameter N, default 8, operand width in bits; SHALL be 4 or more.
REQ-002 CLOCK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset, sampled on the CLOCK rising edge.
REQ-004 START  in  1  request strobe; SHALL be sampled only while idle.
REQ-005 A  in  N  signed multiplicand, two's complement.
REQ-006 B  in  N  signed multiplier, two's complement.
REQ-007 S  out  2N  signed product, registered; SHALL hold its value until the next result or RESET.
REQ-008 Carry_out  out  1  SHALL be 1 when the product does not fit in an N-bit signed value.
REQ-009 BUSY  out  1  SHALL be high from the edge accepting START until the edge producing the result.
REQ-010 DONE  out  1  single-cycle pulse marking a new valid S and Carry_out.

Function
REQ-011 The unit SHALL have states IDLE, RUN and FIX: IDLE->RUN on START (or IDLE->FIX when iteration count is 0); RUN->FIX after the last iteration; FIX->IDLE unconditionally.
REQ-012 On accepting START, the unit SHALL latch A and B and form N-bit unsigned magnitudes: |x| = ~x+1 when x[N-1]=1, else x (so -2^(N-1) maps to 2^(N-1)).
REQ-013 The iteration count K SHALL be the bit-length of |B| (N minus leading zeros from the MSB; 0 when B=0); the count is N when SEQ_MUL_EARLY_EXIT_EN is undefined (REQ-024).
REQ-014 RUN SHALL perform one shift-add step per cycle, LSB of |B| first, for exactly K cycles.
REQ-015 FIX SHALL apply the sign (negate when A[N-1] xor B[N-1], except a zero magnitude stays 0) and register S and Carry_out.
REQ-016 Carry_out SHALL equal 1 iff S lies outside [-2^(N-1), 2^(N-1)-1].
REQ-017 DONE SHALL be high for exactly the one cycle after the FIX edge; with START sampled at edge t, DONE SHALL be high after edge t+K+1.
REQ-018 START while BUSY=1 SHALL be ignored without corrupting the operation in flight.
REQ-019 START high in the DONE cycle SHALL be accepted (back-to-back operation, no idle bubble).
REQ-020 A and B SHALL be don't-care after the accepting edge; later input changes SHALL NOT affect the result.

Reset
REQ-021 While RESET=1, the unit SHALL enter IDLE and drive S=0, Carry_out=0, BUSY=0 and DONE=0, with RESET taking priority over START.
REQ-022 RESET asserted mid-operation SHALL abort the operation with no DONE pulse.
REQ-023 A START in the first cycle after RESET deasserts SHALL be accepted.

Configuration
REQ-024 Macro SEQ_MUL_EARLY_EXIT_EN: when defined, K follows the bit-length of |B| (latency 1..N+1 cycles); when undefined, K=N for every operand (fixed latency N+1), and S and Carry_out SHALL be identical in both builds.

Verification (N=8, SEQ_MUL_EARLY_EXIT_EN defined unless stated)
REQ-025 A=5, B=3, START -> K=2; DONE after 3 cycles; S=15; Carry_out=0.
REQ-026 A=-7, B=6 -> K=3; DONE after 4 cycles; S=-42 (16'hFFD6); Carry_out=0.
REQ-027 A=100, B=-128 -> K=8; DONE after 9 cycles; S=-12800; Carry_out=1; the same case without the macro also gives 9 cycles and identical outputs.
REQ-028 A=-128, B=0 -> DONE after 1 cycle; S=0 (not negated); Carry_out=0; BUSY high for one cycle.
REQ-029 A=3, B=127 with RESET asserted on the 2nd RUN cycle -> next edge S=0, BUSY=0, DONE=0; no DONE pulse follows; then A=2, B=2 -> S=4 after 3 cycles.
REQ-030 START re-pulsed with A=9, B=9 while BUSY, then START in the DONE cycle with A=-2, B=4 -> first S unaffected, second S=-8 after 4 cycles, and DONE pulses are separated by exactly 4 cycles.
